// File: rtl/decode_queue.sv
// decode_queue: decode stage with a circular queue of pre-decoded RV32 instructions.
// Each instruction is decoded as it enters. Its fields are stored in the tail slot, so the
// output path only reads storage selected by the head pointer.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset (clears pointers and count only)
//   flush           drop every queued entry at the next edge (wins over push/pop)
//   in_valid/ready  fetch handshake; in_ready = !full
//   in_pc, in_raw   offered PC and raw instruction word
//   out_valid/ready downstream handshake; out_valid = !empty
//   out_pc, out_raw stored PC and word of the head entry
//   out_rd/rs1/rs2  register addresses, zeroed when the format does not use them
//   out_imm         sign-extended immediate (zimm for CSR-immediate forms)
//   out_class       instruction class, 15 = illegal
//   out_illegal     head entry is not a supported encoding
//   count           current occupancy
module decode_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned ENABLE_M     = 1,
  parameter int unsigned ENABLE_ZICSR = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [31:0]                    in_pc,
  input  logic [31:0]                    in_raw,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [31:0]                    out_pc,
  output logic [31:0]                    out_raw,
  output logic [4:0]                     out_rd,
  output logic [4:0]                     out_rs1,
  output logic [4:0]                     out_rs2,
  output logic [31:0]                    out_imm,
  output logic [3:0]                     out_class,
  output logic                           out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [3:0] ClsAluReg = 4'd0;
  localparam logic [3:0] ClsAluImm = 4'd1;
  localparam logic [3:0] ClsUpper  = 4'd2;
  localparam logic [3:0] ClsJal    = 4'd3;
  localparam logic [3:0] ClsJalr   = 4'd4;
  localparam logic [3:0] ClsBranch = 4'd5;
  localparam logic [3:0] ClsLoad   = 4'd6;
  localparam logic [3:0] ClsStore  = 4'd7;
  localparam logic [3:0] ClsCsr    = 4'd8;
  localparam logic [3:0] ClsMulDiv = 4'd9;
  localparam logic [3:0] ClsSystem = 4'd10;
  localparam logic [3:0] ClsFence  = 4'd11;
  localparam logic [3:0] ClsIllegal = 4'd15;

  // FmtN: no operand zeroing and a zero immediate (fence, unknown opcodes).
  typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ, FmtN} fmt_e;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  fmt_e        dec_fmt;
  logic [3:0]  dec_cls;
  logic        dec_csr_imm;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_imm;

  assign opcode = in_raw[6:0];
  assign funct3 = in_raw[14:12];
  assign funct7 = in_raw[31:25];

  // Class and format selection.
  always_comb begin
    dec_fmt     = FmtN;
    dec_cls     = ClsIllegal;
    dec_csr_imm = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec_fmt = FmtR;
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          dec_cls = ClsAluReg;
        end else if (funct7 == 7'b0000001 && ENABLE_M != 0) begin
          dec_cls = ClsMulDiv;
        end
      end
      7'b0010011: begin
        dec_fmt = FmtI;
        if (funct3 == 3'b001) begin
          if (funct7 == 7'b0000000) dec_cls = ClsAluImm;
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0000000 || funct7 == 7'b0100000) dec_cls = ClsAluImm;
        end else begin
          dec_cls = ClsAluImm;
        end
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FmtU;
        dec_cls = ClsUpper;
      end
      7'b1101111: begin
        dec_fmt = FmtJ;
        dec_cls = ClsJal;
      end
      7'b1100111: begin
        dec_fmt = FmtI;
        if (funct3 == 3'b000) dec_cls = ClsJalr;
      end
      7'b1100011: begin
        dec_fmt = FmtB;
        if (funct3 != 3'b010 && funct3 != 3'b011) dec_cls = ClsBranch;
      end
      7'b0000011: begin
        dec_fmt = FmtI;
        if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) dec_cls = ClsLoad;
      end
      7'b0100011: begin
        dec_fmt = FmtS;
        if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) dec_cls = ClsStore;
      end
      7'b0001111: begin
        if (funct3 == 3'b000) dec_cls = ClsFence;
      end
      7'b1110011: begin
        if (funct3 == 3'b000) begin
          dec_fmt = FmtR;
          // Only ecall, ebreak and mret are supported exact encodings.
          if (in_raw == 32'h0000_0073 || in_raw == 32'h0010_0073 ||
              in_raw == 32'h3020_0073) begin
            dec_cls = ClsSystem;
          end
        end else if (funct3 == 3'b100) begin
          dec_fmt = FmtR;
        end else begin
          dec_fmt     = FmtI;
          dec_csr_imm = funct3[2];
          if (ENABLE_ZICSR != 0) dec_cls = ClsCsr;
        end
      end
      default: ;
    endcase
  end

  // Operand and immediate extraction from the selected format.
  always_comb begin
    dec_rd  = in_raw[11:7];
    dec_rs1 = in_raw[19:15];
    dec_rs2 = in_raw[24:20];
    dec_imm = 32'h0;
    case (dec_fmt)
      FmtI: begin
        dec_rs2 = 5'd0;
        dec_imm = {{20{in_raw[31]}}, in_raw[31:20]};
      end
      FmtS: begin
        dec_rd  = 5'd0;
        dec_imm = {{20{in_raw[31]}}, in_raw[31:25], in_raw[11:7]};
      end
      FmtB: begin
        dec_rd  = 5'd0;
        dec_imm = {{19{in_raw[31]}}, in_raw[31], in_raw[7], in_raw[30:25], in_raw[11:8], 1'b0};
      end
      FmtU: begin
        dec_rs1 = 5'd0;
        dec_rs2 = 5'd0;
        dec_imm = {in_raw[31:12], 12'h000};
      end
      FmtJ: begin
        dec_rs1 = 5'd0;
        dec_rs2 = 5'd0;
        dec_imm = {{11{in_raw[31]}}, in_raw[31], in_raw[19:12], in_raw[20], in_raw[30:21],
                   1'b0};
      end
      default: ;
    endcase
    if (dec_csr_imm) begin
      dec_rs1 = 5'd0;
      dec_imm = {27'h0, in_raw[19:15]};
    end
  end

  // Queue control.
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;
  logic            push, pop, wr_en;

  assign in_ready  = (count_q != CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign wr_en     = push & ~flush & ~rst;
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PtrW'(1);
      if (pop)  head_q <= head_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Storage is never reset; occupancy alone decides what is valid.
  logic [31:0] pc_mem  [DEPTH];
  logic [31:0] raw_mem [DEPTH];
  logic [4:0]  rd_mem  [DEPTH];
  logic [4:0]  rs1_mem [DEPTH];
  logic [4:0]  rs2_mem [DEPTH];
  logic [31:0] imm_mem [DEPTH];
  logic [3:0]  cls_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[tail_q]  <= in_pc;
      raw_mem[tail_q] <= in_raw;
      rd_mem[tail_q]  <= dec_rd;
      rs1_mem[tail_q] <= dec_rs1;
      rs2_mem[tail_q] <= dec_rs2;
      imm_mem[tail_q] <= dec_imm;
      cls_mem[tail_q] <= dec_cls;
    end
  end

  assign out_pc      = pc_mem[head_q];
  assign out_raw     = raw_mem[head_q];
  assign out_rd      = rd_mem[head_q];
  assign out_rs1     = rs1_mem[head_q];
  assign out_rs2     = rs2_mem[head_q];
  assign out_imm     = imm_mem[head_q];
  assign out_class   = cls_mem[head_q];
  assign out_illegal = (cls_mem[head_q] == ClsIllegal);

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: two instances share the stimulus, one with all extensions enabled
// and one with RV32M and Zicsr disabled. A queue of {pc, raw} plus an ISA-level decoder
// provides the expected outputs.
module tb_decode_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_raw;

  logic          in_ready, out_valid, out_illegal;
  logic [31:0]   out_pc, out_raw, out_imm;
  logic [4:0]    out_rd, out_rs1, out_rs2;
  logic [3:0]    out_class;
  logic [CW-1:0] count;

  logic          m0_in_ready, m0_out_valid, m0_out_illegal;
  logic [31:0]   m0_out_pc, m0_out_raw, m0_out_imm;
  logic [4:0]    m0_out_rd, m0_out_rs1, m0_out_rs2;
  logic [3:0]    m0_out_class;
  logic [CW-1:0] m0_count;

  decode_queue #(.DEPTH(DEPTH), .ENABLE_M(1), .ENABLE_ZICSR(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_raw(in_raw),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_raw(out_raw),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_class(out_class), .out_illegal(out_illegal), .count(count)
  );

  decode_queue #(.DEPTH(DEPTH), .ENABLE_M(0), .ENABLE_ZICSR(0)) dut_min (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(m0_in_ready), .in_pc(in_pc), .in_raw(in_raw),
    .out_valid(m0_out_valid), .out_ready(out_ready), .out_pc(m0_out_pc),
    .out_raw(m0_out_raw), .out_rd(m0_out_rd), .out_rs1(m0_out_rs1), .out_rs2(m0_out_rs2),
    .out_imm(m0_out_imm), .out_class(m0_out_class), .out_illegal(m0_out_illegal),
    .count(m0_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] raw;
  } ent_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [3:0]  cls;
    logic        illegal;
  } dec_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  // ISA-level reference: pick the instruction kind, then take fields as the manual lays
  // them out for that kind.
  function automatic dec_t ref_decode(logic [31:0] w, bit en_m, bit en_csr);
    dec_t  d;
    int    cls;
    string fmt;
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    logic signed [11:0] i_imm = w[31:20];
    logic signed [11:0] s_imm = {w[31:25], w[11:7]};
    logic signed [12:0] b_imm = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    logic signed [20:0] j_imm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    bit zimm = 0;
    cls = 15;
    fmt = "N";
    case (op)
      7'h33: begin
        fmt = "R";
        if (f7 == 7'h00) cls = 0;
        else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) cls = 0;
        else if (f7 == 7'h01 && en_m) cls = 9;
      end
      7'h13: begin
        fmt = "I";
        cls = 1;
        if (f3 == 1 && f7 != 7'h00) cls = 15;
        if (f3 == 5 && f7 != 7'h00 && f7 != 7'h20) cls = 15;
      end
      7'h37, 7'h17: begin fmt = "U"; cls = 2; end
      7'h6f: begin fmt = "J"; cls = 3; end
      7'h67: begin fmt = "I"; if (f3 == 0) cls = 4; end
      7'h63: begin fmt = "B"; if (!(f3 inside {2, 3})) cls = 5; end
      7'h03: begin fmt = "I"; if (f3 inside {0, 1, 2, 4, 5}) cls = 6; end
      7'h23: begin fmt = "S"; if (f3 inside {0, 1, 2}) cls = 7; end
      7'h0f: begin if (f3 == 0) cls = 11; end
      7'h73: begin
        if (f3 == 0) begin
          fmt = "R";
          if (w == 32'h00000073 || w == 32'h00100073 || w == 32'h30200073) cls = 10;
        end else if (f3 == 4) begin
          fmt = "R";
        end else begin
          fmt = "I";
          zimm = (f3 >= 5);
          if (en_csr) cls = 8;
        end
      end
      default: ;
    endcase
    d.rd  = (fmt == "S" || fmt == "B") ? 5'd0 : w[11:7];
    d.rs1 = (fmt == "U" || fmt == "J" || zimm) ? 5'd0 : w[19:15];
    d.rs2 = (fmt == "I" || fmt == "U" || fmt == "J") ? 5'd0 : w[24:20];
    if (zimm) d.imm = {27'd0, w[19:15]};
    else if (fmt == "I") d.imm = 32'(i_imm);
    else if (fmt == "S") d.imm = 32'(s_imm);
    else if (fmt == "B") d.imm = 32'(b_imm);
    else if (fmt == "J") d.imm = 32'(j_imm);
    else if (fmt == "U") d.imm = w & 32'hFFFF_F000;
    else d.imm = 32'd0;
    d.cls     = 4'(cls);
    d.illegal = (cls == 15);
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [11] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
                              7'h23, 7'h0f, 7'h73};
    logic [31:0] sys [3] = '{32'h00000073, 32'h00100073, 32'h30200073};
    int k;
    w = $urandom;
    k = $urandom_range(0, 13);
    if (k < 11) w[6:0] = ops[k];
    else if (k == 11) w = sys[$urandom_range(0, 2)];
    else if (k == 12) begin
      w[6:0]   = 7'h33;
      w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h01 : 7'h20;
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    dec_t d, dm;
    chk("count", 32'(count), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("min_count", 32'(m0_count), 32'(q.size()));
    if (q.size() > 0) begin
      d  = ref_decode(q[0].raw, 1, 1);
      dm = ref_decode(q[0].raw, 0, 0);
      chk("out_pc", out_pc, q[0].pc);
      chk("out_raw", out_raw, q[0].raw);
      chk("out_class", 32'(out_class), 32'(d.cls));
      chk("out_illegal", 32'(out_illegal), 32'(d.illegal));
      chk("min_class", 32'(m0_out_class), 32'(dm.cls));
      chk("min_illegal", 32'(m0_out_illegal), 32'(dm.illegal));
      if (!d.illegal) begin
        chk("out_rd", 32'(out_rd), 32'(d.rd));
        chk("out_rs1", 32'(out_rs1), 32'(d.rs1));
        chk("out_rs2", 32'(out_rs2), 32'(d.rs2));
        chk("out_imm", out_imm, d.imm);
      end
    end
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, check at
  // the next falling edge.
  task automatic cycle(input logic iv, input logic [31:0] pc, input logic [31:0] raw,
                       input logic ordy, input logic fl, input logic rs);
    bit do_push, do_pop;
    in_valid  = iv;
    in_pc     = pc;
    in_raw    = raw;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    @(posedge clk);
    do_push = iv && (q.size() < DEPTH);
    do_pop  = ordy && (q.size() > 0);
    if (rs || fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{pc: pc, raw: raw});
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_raw = '0;
    @(negedge clk);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    chk("reset_count", 32'(count), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_out_valid", 32'(out_valid), 0);

    // addi x1,x0,5 appears one cycle after the push.
    cycle(1, 32'h100, 32'h00500093, 0, 0, 0);
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_rd", 32'(out_rd), 1);
    chk("addi_rs1", 32'(out_rs1), 0);
    chk("addi_rs2", 32'(out_rs2), 0);
    chk("addi_imm", out_imm, 5);
    chk("addi_class", 32'(out_class), 1);
    chk("addi_count", 32'(count), 1);
    cycle(0, 0, 0, 1, 0, 0);

    // Fill past full, then drain in order; head starts at 1 so the pointers wrap.
    for (int i = 0; i < DEPTH + 2; i++) cycle(1, 32'h200 + 4 * i, rand_instr(), 0, 0, 0);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_count", 32'(count), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      chk("fifo_pc", out_pc, 32'h200 + 4 * i);
      cycle(0, 0, 0, 1, 0, 0);
    end
    chk("drained_valid", 32'(out_valid), 0);

    // Sustained push and pop keeps occupancy constant.
    cycle(1, 32'h300, rand_instr(), 0, 0, 0);
    cycle(1, 32'h304, rand_instr(), 0, 0, 0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      cycle(1, 32'h308 + 4 * i, rand_instr(), 1, 0, 0);
      chk("steady_count", 32'(count), 2);
    end
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);

    // Directed decodes.
    cycle(1, 32'h400, 32'hFE208EE3, 0, 0, 0);
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    chk("beq_rd", 32'(out_rd), 0);
    chk("beq_class", 32'(out_class), 5);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 32'h404, 32'h3003D1F3, 0, 0, 0);
    chk("csrrwi_rs1", 32'(out_rs1), 0);
    chk("csrrwi_imm", out_imm, 7);
    chk("csrrwi_class", 32'(out_class), 8);
    chk("csrrwi_min_illegal", 32'(m0_out_illegal), 1);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 32'h408, 32'h022081B3, 0, 0, 0);
    chk("mul_class", 32'(out_class), 9);
    chk("mul_min_class", 32'(m0_out_class), 15);
    chk("mul_min_illegal", 32'(m0_out_illegal), 1);
    cycle(0, 0, 0, 1, 0, 0);

    // Flush, then reset, with a same-cycle push and pop.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 3; i++) cycle(1, 32'h500 + 4 * i, rand_instr(), 0, 0, 0);
      chk("pre_discard_count", 32'(count), 3);
      cycle(1, 32'h600, 32'h00500093, 1, (pass == 0), (pass == 1));
      chk("discard_count", 32'(count), 0);
      chk("discard_valid", 32'(out_valid), 0);
      chk("discard_in_ready", 32'(in_ready), 1);
      cycle(0, 0, 0, 0, 0, 0);
      chk("discard_not_stored", 32'(count), 0);
    end

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 32'h1000 + 4 * i, rand_instr(),
            $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0,
            $urandom_range(0, 80) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
# decode_queue

Buffered, parametrised decode stage between instruction fetch and the register-read/execute stage. It accepts raw RV32 instructions with their PC over a valid/ready handshake, decodes each one on entry, and holds up to DEPTH decoded entries in a circular queue. The head entry is presented downstream, with register addresses, immediate, instruction class and an illegal flag. A flush input discards all queued work on branch mispredict or trap.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, 2..16.
- ENABLE_M, 1: when 0, RV32M encodings are flagged illegal.
- ENABLE_ZICSR, 1: when 0, CSR encodings (opcode 1110011, funct3 != 000/100) are flagged illegal.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all entries this cycle.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  queue can accept; equals !full.
- in_pc  in  32  PC of the offered instruction.
- in_raw  in  32  raw instruction word.
- out_valid  out  1  head entry present; equals !empty.
- out_ready  in  1  downstream consumes the head.
- out_pc, out_raw  out  32 each  stored PC and word.
- out_rd, out_rs1, out_rs2  out  5 each  register addresses, zeroed when the format does not use them.
- out_imm  out  32  sign-extended immediate (zimm for CSR-immediate forms).
- out_class  out  4  0 ALU-reg, 1 ALU-imm, 2 LUI/AUIPC, 3 JAL, 4 JALR, 5 branch, 6 load, 7 store, 8 CSR, 9 MUL/DIV, 10 system (ecall/ebreak/mret), 11 fence, 15 illegal.
- out_illegal  out  1  entry is not a supported encoding.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Decoding happens combinationally on in_raw. The decoded fields are written into the tail slot on push, so there is no decode logic on the output path.
- Formats follow RV32I. I-type: opcodes 1100111, 0000011, 0010011, and CSR. S-type: 0100011. B-type: 1100011. U-type: 0110111, 0010111. J-type: 1101111. R-type: 0110011 and system.
- Register address zeroing:
  - rs1 is zero for U/J and for CSR-immediate forms (funct3 101/110/111).
  - rs2 is zero for I/U/J.
  - rd is zero for S/B.
- Immediates:
  - I, S, B, J immediates are sign-extended from bit 31.
  - B and J immediates have bit 0 = 0.
  - U immediate is {raw[31:12], 12'b0}.
  - CSR-immediate forms carry {27'b0, raw[19:15]}.
  - All others are 0.
- Illegal detection:
  - Any encoding outside RV32I, fence, ecall, ebreak, mret, Zicsr and RV32M is illegal.
  - Loads with funct3 not in {000, 001, 010, 100, 101} are illegal.
  - Stores with funct3 not in {000, 001, 010} are illegal.
  - Shift-immediates with a bad funct7 are illegal.
  - Extensions disabled by parameter are illegal.
  - Illegal entries are still queued, with class 15 and out_illegal=1, so the trap is raised in order.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Pointers are log2(DEPTH) bits and wrap naturally. count += push − pop.
- Simultaneous push and pop when neither full nor empty: count is unchanged and both pointers advance.
- Full (count==DEPTH): in_ready=0. No pass-through; a pop this cycle frees space visible next cycle.
- Empty: out_valid=0. There is no bypass, so a pushed entry is visible the next cycle.
- Flush:
  - Pointers and count go to 0 at the edge.
  - Flush has priority over a same-cycle push and pop; the push is dropped, and fetch must re-offer.
  - in_ready is still driven as !full during the flush cycle.
- out_* data fields are don't-care when out_valid=0, but are driven from the head slot (no X-masking).

## Timing
- Reset (rst=1 at an edge) behaves exactly like flush:
  - count=0, out_valid=0, in_ready=1 from the following cycle.
  - Storage contents are not cleared.
  - Reset mid-operation discards all entries.
- Latency from push at edge N to out_valid=1 with that entry: 1 cycle (visible after edge N).
- Throughput: one push and one pop per cycle sustained.
- in_ready and out_valid are functions of registered count only; no combinational path from out_ready to in_ready or from in_valid to out_valid.
- out_* fields are registered storage reads, muxed by the head pointer.

## Test plan
- Reset, then push addi x1,x0,5 (0x00500093) at PC 0x100 → next cycle out_valid=1, out_rd=1, out_rs1=0, out_rs2=0, out_imm=5, out_class=1, count=1.
- Push DEPTH entries with out_ready=0 → in_ready=0 at count=DEPTH; further in_valid is ignored. Then pop all → entries emerge in FIFO order with correct PCs, including across pointer wrap.
- Steady push and pop every cycle for 3×DEPTH instructions → count stays constant and no entry is lost or duplicated.
- Decoding checks:
  - beq x1,x2,-4 (0xFE208EE3) → out_imm=0xFFFFFFFC, out_rd=0, class 5.
  - csrrwi x3,0x300,7 (0x3003D1F3) → out_rs1=0, out_imm=7, class 8.
- With ENABLE_M=0, push mul (0x022081B3) → out_illegal=1, out_class=15. With ENABLE_M=1 the same word gives class 9.
- Three entries queued; assert flush together with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, and the offered instruction is not stored. Repeat the same sequence using rst instead of flush → identical result.
